adc_rslot_deframer: RTL and testbench

//   Deframes the right-channel slot of the WM8731 ADC serial stream (master mode, 16-bit, MSB-first,

---
 rtl/audio_i2s_pkg.sv | 25 ++
 rtl/i2s_slot_counter.sv | 34 +++
 rtl/adc_rslot_deframer.sv | 112 +++++++++++
 tb/tb_adc_rslot_deframer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/audio_i2s_pkg.sv
// Shared audio serial-port definitions for the WM8731 ADC/DAC slot logic.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
package audio_i2s_pkg;

    // Slot geometry shared by the DAC writer, the ADC reader and the deframers.
    localparam int I2S_SLOT_W = 32;
    localparam int I2S_DATA_W = 16;

    // Number of leading padding bits in a right-justified slot.
    localparam int PAD_BITS = I2S_SLOT_W - I2S_DATA_W;

    // Right-slot deframer state encoding.
    typedef enum logic [1:0] {
        SHIFT = 2'd0,
        DONE  = 2'd1,
        OVF   = 2'd2
    } rslotState_t;

    // Padding width for a slot/sample geometry other than the defaults.
    function automatic int padBits(input int slotW, input int dataW);
        return slotW - dataW;
    endfunction

endpackage

// File: rtl/i2s_slot_counter.sv
// Saturating per-slot BCLK edge counter with boundary decodes.
// Latency: count updates on every rising AUD_BCLK edge; decodes are combinational from count.
// Backpressure: none; counts every edge and sticks at all-ones.
//
// Ports:
//   AUD_BCLK     in   codec bit clock (rising edge counts)
//   AUD_ADCLRCK  in   asynchronous active-high clear
//   count        out  edges seen since clear, saturating at 2**CNT_W-1
//   atPadEnd     out  count == PAD_BITS (first sample bit arrives on this edge)
//   atLast       out  count == SLOT_W-1 (final slot bit arrives on this edge)
module i2s_slot_counter #(
    parameter int CNT_W    = 6,
    parameter int SLOT_W   = 32,
    parameter int PAD_BITS = 16
) (
    input  logic             AUD_BCLK,
    input  logic             AUD_ADCLRCK,
    output logic [CNT_W-1:0] count,
    output logic             atPadEnd,
    output logic             atLast
);

    always_ff @(posedge AUD_BCLK or posedge AUD_ADCLRCK) begin
        if (AUD_ADCLRCK) begin
            count <= '0;
        end else if (count != {CNT_W{1'b1}}) begin
            count <= count + CNT_W'(1);
        end
    end

    assign atPadEnd = (count == CNT_W'(PAD_BITS));
    assign atLast   = (count == CNT_W'(SLOT_W - 1));

endmodule

// File: rtl/adc_rslot_deframer.sv
// Deframes the right-channel slot of the WM8731 ADC stream into one signed sample plus diagnostics.
// Latency: oValid/oRData appear right after the SLOT_W-th rising BCLK edge of the right slot.
// Backpressure: none; the sample is held until ADCLRCK rises (left slot), which clears everything.
//
// Ports:
//   AUD_BCLK     in   codec bit clock, data sampled on rising edge
//   AUD_ADCLRCK  in   asynchronous active-high clear (high = left slot)
//   iAUD_ADCDAT  in   codec serial ADC data, MSB-first, right-justified
//   oRData       out  raw two's-complement sample, valid while oValid=1
//   oValid       out  sample complete; held until clear
//   oPadErr      out  sticky: a 1 was seen in the padding bits
//   oOvf         out  sticky: more than SLOT_W edges in this slot
//   oBitCnt      out  edges seen this slot, saturating
module adc_rslot_deframer
    import audio_i2s_pkg::*;
#(
    parameter int SLOT_W = I2S_SLOT_W,
    parameter int DATA_W = I2S_DATA_W,
    parameter int CNT_W  = 6
) (
    input  logic              AUD_BCLK,
    input  logic              AUD_ADCLRCK,
    input  logic              iAUD_ADCDAT,
    output logic [DATA_W-1:0] oRData,
    output logic              oValid,
    output logic              oPadErr,
    output logic              oOvf,
    output logic [CNT_W-1:0]  oBitCnt
);

    localparam int PadW = padBits(SLOT_W, DATA_W);

    rslotState_t       state, stateNxt;
    // Only DATA_W-1 history bits are needed: the final bit goes straight into oRData.
    logic [DATA_W-2:0] sreg, sregNxt;
    logic [DATA_W-1:0] rDataNxt;
    logic              validNxt, padErrNxt, ovfNxt;

    logic              atPadEnd, atLast;
    logic              pastPad;
    logic              inPad;

    i2s_slot_counter #(
        .CNT_W    (CNT_W),
        .SLOT_W   (SLOT_W),
        .PAD_BITS (PadW)
    ) u_cnt (
        .AUD_BCLK    (AUD_BCLK),
        .AUD_ADCLRCK (AUD_ADCLRCK),
        .count       (oBitCnt),
        .atPadEnd    (atPadEnd),
        .atLast      (atLast)
    );

    // pastPad remembers that the counter has crossed the padding boundary, so the
    // padding window is "count < PAD_BITS" without a magnitude comparator.
    assign inPad = !pastPad && !atPadEnd;

    always_ff @(posedge AUD_BCLK or posedge AUD_ADCLRCK) begin
        if (AUD_ADCLRCK) begin
            state   <= SHIFT;
            sreg    <= '0;
            oRData  <= '0;
            oValid  <= 1'b0;
            oPadErr <= 1'b0;
            oOvf    <= 1'b0;
            pastPad <= 1'b0;
        end else begin
            state   <= stateNxt;
            sreg    <= sregNxt;
            oRData  <= rDataNxt;
            oValid  <= validNxt;
            oPadErr <= padErrNxt;
            oOvf    <= ovfNxt;
            pastPad <= pastPad | atPadEnd;
        end
    end

    always_comb begin
        stateNxt  = state;
        sregNxt   = sreg;
        rDataNxt  = oRData;
        validNxt  = oValid;
        padErrNxt = oPadErr;
        ovfNxt    = oOvf;
        unique case (state)
            SHIFT: begin
                sregNxt = {sreg[DATA_W-3:0], iAUD_ADCDAT};
                if (inPad && iAUD_ADCDAT) begin
                    padErrNxt = 1'b1;
                end
                if (atLast) begin
                    rDataNxt = {sreg, iAUD_ADCDAT};
                    validNxt = 1'b1;
                    stateNxt = DONE;
                end
            end
            DONE: begin
                // Extra edge: the first SLOT_W bits stay authoritative.
                ovfNxt   = 1'b1;
                stateNxt = OVF;
            end
            OVF: begin
                stateNxt = OVF;
            end
            default: begin
                stateNxt = SHIFT;
            end
        endcase
    end

endmodule

// File: tb/tb_adc_rslot_deframer.sv
module tb_adc_rslot_deframer;

    localparam int SLOT = 32;
    localparam int DW   = 16;
    localparam int PADN = SLOT - DW;
    localparam int CMAX = 63;

    logic        AUD_BCLK;
    logic        AUD_ADCLRCK;
    logic        iAUD_ADCDAT;
    logic [15:0] oRData;
    logic        oValid;
    logic        oPadErr;
    logic        oOvf;
    logic [5:0]  oBitCnt;

    int total = 0;
    int bad   = 0;

    adc_rslot_deframer #(
        .SLOT_W (32),
        .DATA_W (16),
        .CNT_W  (6)
    ) dut (
        .AUD_BCLK    (AUD_BCLK),
        .AUD_ADCLRCK (AUD_ADCLRCK),
        .iAUD_ADCDAT (iAUD_ADCDAT),
        .oRData      (oRData),
        .oValid      (oValid),
        .oPadErr     (oPadErr),
        .oOvf        (oOvf),
        .oBitCnt     (oBitCnt)
    );

    initial AUD_BCLK = 1'b0;
    always #5 AUD_BCLK = ~AUD_BCLK;

    initial begin
        #300000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slot bit stream: element i is the bit presented before rising edge i+1.
    function automatic bit [79:0] mkSlot(input bit [15:0] pad, input bit [15:0] data, input bit randTail);
        bit [79:0] b;
        b = '0;
        for (int j = 0; j < PADN; j++) b[j] = pad[PADN-1-j];
        for (int m = 0; m < DW; m++) b[PADN+m] = data[DW-1-m];
        for (int j = SLOT; j < 80; j++) b[j] = randTail ? 1'($urandom_range(0, 1)) : 1'b0;
        return b;
    endfunction

    // Expected outputs after k rising edges, derived directly from the slot rules.
    task automatic expectAfter(input bit [79:0] b, input int k, output logic v, output logic [15:0] d,
                               output logic p, output logic o, output logic [5:0] c);
        logic [15:0] acc;
        acc = '0;
        v = (k >= SLOT);
        for (int j = PADN; j < SLOT; j++) acc = {acc[14:0], b[j]};
        d = v ? acc : 16'h0;
        p = 1'b0;
        for (int j = 0; j < PADN && j < k; j++) p = p | b[j];
        o = (k > SLOT);
        c = 6'((k > CMAX) ? CMAX : k);
    endtask

    task automatic checkCleared(input string tag);
        check({tag, ".rdata"}, 32'(oRData), 32'h0);
        check({tag, ".valid"}, 32'(oValid), 32'h0);
        check({tag, ".pad"},   32'(oPadErr), 32'h0);
        check({tag, ".ovf"},   32'(oOvf), 32'h0);
        check({tag, ".cnt"},   32'(oBitCnt), 32'h0);
    endtask

    // Runs one right slot of n edges, checking every output after each edge,
    // then raises ADCLRCK and checks the asynchronous clear.
    task automatic runSlot(input string tag, input bit [79:0] b, input int n);
        logic v, p, o;
        logic [15:0] d;
        logic [5:0] c;
        @(negedge AUD_BCLK);
        AUD_ADCLRCK = 1'b0;
        iAUD_ADCDAT = b[0];
        for (int i = 0; i < n; i++) begin
            @(posedge AUD_BCLK);
            #1;
            expectAfter(b, i + 1, v, d, p, o, c);
            check({tag, ".valid"}, 32'(oValid), 32'(v));
            check({tag, ".rdata"}, 32'(oRData), 32'(d));
            check({tag, ".pad"},   32'(oPadErr), 32'(p));
            check({tag, ".ovf"},   32'(oOvf), 32'(o));
            check({tag, ".cnt"},   32'(oBitCnt), 32'(c));
            @(negedge AUD_BCLK);
            if (i + 1 < n && i + 1 < 80) iAUD_ADCDAT = b[i+1];
        end
        #2;
        AUD_ADCLRCK = 1'b1;
        #1;
        checkCleared({tag, ".clr"});
        // Left slot: clock and data keep running while held in reset.
        for (int i = 0; i < 3; i++) begin
            iAUD_ADCDAT = 1'($urandom_range(0, 1));
            @(posedge AUD_BCLK);
            #1;
        end
        checkCleared({tag, ".hold"});
    endtask

    initial begin
        bit [79:0] b;
        AUD_ADCLRCK = 1'b1;
        iAUD_ADCDAT = 1'b1;
        repeat (3) @(posedge AUD_BCLK);
        #1;
        checkCleared("reset");

        // Nominal sample, clean padding.
        b = mkSlot(16'h0000, 16'h8001, 1'b0);
        runSlot("T1", b, 32);

        // Padding fault on slot bit 3.
        b = mkSlot(16'h1000, 16'h1234, 1'b0);
        runSlot("T2", b, 32);

        // Over-length slot with junk after the sample.
        b = mkSlot(16'h0000, 16'hA5C3, 1'b1);
        runSlot("T3", b, 35);

        // Short slot: never valid, cleared on ADCLRCK rise.
        b = mkSlot(16'h0000, 16'hFFFF, 1'b0);
        runSlot("T4", b, 20);

        // Back-to-back frames.
        b = mkSlot(16'h0000, 16'h7FFF, 1'b0);
        runSlot("T5a", b, 32);
        b = mkSlot(16'h0000, 16'h0000, 1'b0);
        runSlot("T5b", b, 32);
        b = mkSlot(16'h0000, 16'hFFFF, 1'b0);
        runSlot("T5c", b, 32);

        // Counter saturation.
        b = mkSlot(16'h0000, 16'h4321, 1'b1);
        runSlot("T6", b, 80);

        // Randomised slots: random padding faults, data and slot length.
        for (int r = 0; r < 12; r++) begin
            bit [15:0] pad;
            pad = ($urandom_range(0, 2) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'h0;
            b = mkSlot(pad, 16'($urandom), 1'b1);
            runSlot("RND", b, int'($urandom_range(14, 40)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
